// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory read port plus the issue handshake
// towards the cycle-count/address-latch stage.
interface fetch_unit_if;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic [2:0] opcode;
    logic [4:0] address;
    logic       instr_valid;
    logic       instr_ready;
    logic       exe_done;
    logic       acc_zero;
    logic       halted;

    modport master (
        output mem_addr, mem_rd, opcode, address, instr_valid, halted,
        input  mem_rdata, instr_ready, exe_done, acc_zero
    );

    modport slave (
        input  mem_addr, mem_rd, opcode, address, instr_valid, halted,
        output mem_rdata, instr_ready, exe_done, acc_zero
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 8-bit RISC CPU: owns the 5-bit PC, resolves JMP/SKZ/HLT.
// Build option FETCH_HALT_EN: when defined HLT stops the unit, otherwise HLT is a no-op.
module fetch_unit #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    // Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b111;
`ifdef FETCH_HALT_EN
    localparam logic [2:0] OP_HLT = 3'b000;
`endif

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3
`ifdef FETCH_HALT_EN
        , HALT = 3'd4
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [4:0] mem_addr_q, mem_addr_d;
    logic       mem_rd_q, mem_rd_d;
    logic       instr_valid_q, instr_valid_d;
    logic       handshake_s;

    assign handshake_s = (state_q == ISSUE) && bus.instr_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the first FETCH after reset spends one edge raising mem_rd
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_rd_q) state_d = LOAD;
                else          state_d = FETCH;
            end
            LOAD: state_d = ISSUE;
            ISSUE: begin
                if (handshake_s) begin
                    if (ir_q[7:5] == OP_JMP) state_d = FETCH;
`ifdef FETCH_HALT_EN
                    else if (ir_q[7:5] == OP_HLT) state_d = HALT;
`endif
                    else state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (bus.exe_done) state_d = FETCH;
                else              state_d = WAIT;
            end
`ifdef FETCH_HALT_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Output/datapath next values; registered outputs are derived from the next state
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        case (state_q)
            LOAD: begin
                ir_d = bus.mem_rdata;
                pc_d = pc_q + 5'd1;
            end
            ISSUE: begin
                if (handshake_s && (ir_q[7:5] == OP_JMP)) pc_d = ir_q[4:0];
                else                                      pc_d = pc_q;
            end
            WAIT: begin
                if (bus.exe_done && bus.acc_zero && (ir_q[7:5] == OP_SKZ)) pc_d = pc_q + 5'd1;
                else                                                        pc_d = pc_q;
            end
            default: pc_d = pc_q;
        endcase
        mem_rd_d      = (state_d == FETCH);
        mem_addr_d    = mem_rd_d ? pc_d : mem_addr_q;
        instr_valid_d = (state_d == ISSUE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            ir_q          <= 8'd0;
            mem_addr_q    <= 5'd0;
            mem_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q;

    // Halt flag rises the cycle after the HLT handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_d == HALT);
        end
    end

    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.opcode      = ir_q[7:5];
    assign bus.address     = ir_q[4:0];
endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage of the 8-bit RISC CPU; sits directly upstream of the per-instruction cycle-count/address-latch stage and feeds it `opcode` and `address`.
- Owns the 5-bit program counter and reads 8-bit instruction words from synchronous program memory.
- Splits each word into opcode[7:5] and operand address[4:0] and presents them with a valid/ready handshake.
- Resolves JMP, SKZ and HLT control flow before the next fetch.

## Interface
Parameters:
- RESET_PC, 5'd0, program counter value after reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately when low.
- mem_addr  output  5  program memory read address.
- mem_rd  output  1  program memory read strobe.
- mem_rdata  input  8  instruction word; valid exactly one cycle after the `mem_rd` cycle.
- opcode  output  3  opcode of the issued instruction, ir[7:5].
- address  output  5  operand address of the issued instruction, ir[4:0].
- instr_valid  output  1  `opcode`/`address` are valid.
- instr_ready  input  1  downstream accepts the instruction.
- exe_done  input  1  one-cycle pulse; downstream has finished the accepted instruction.
- acc_zero  input  1  accumulator-is-zero flag; sampled only on `exe_done` for SKZ.
- halted  output  1  HLT has been retired; the fetch unit is stopped.

## Operation
- Opcode encoding: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- FSM states: FETCH, LOAD, ISSUE, WAIT, HALT. Reset state is FETCH.
- FETCH: drive `mem_rd`=1 and `mem_addr`=pc, then go to LOAD.
- LOAD: capture `mem_rdata` into ir, set pc <= pc+1, then go to ISSUE.
- ISSUE: hold `instr_valid`=1; `opcode` and `address` are driven from ir and stay stable until `instr_ready`. The handshake completes in a cycle where valid && ready. Exit on handshake:
  - JMP: pc <= address, go to FETCH; no wait for `exe_done`.
  - HLT: go to HALT.
  - any other opcode: go to WAIT.
- WAIT: hold until `exe_done`=1.
  - If ir is SKZ and `acc_zero`=1: pc <= pc+1, which skips the next word.
  - Then go to FETCH.
- HALT: `halted`=1; `mem_rd`=0; stays in HALT until `rst_n` is asserted.
- PC arithmetic is 5-bit modulo 32: 31+1 -> 0; SKZ skip from pc=31 -> 0.
- `exe_done` is ignored in every state other than WAIT.
- `instr_ready` is ignored in every state other than ISSUE.

## Timing
- Reset values: pc=RESET_PC, ir=0, `mem_addr`=0, `mem_rd`=0, `opcode`=0, `address`=0, `instr_valid`=0, `halted`=0, state=FETCH.
- Fetch-to-issue latency: `instr_valid` rises 2 cycles after the `mem_rd` cycle.
- Minimum instruction period: 4 cycles (FETCH, LOAD, ISSUE with ready already high, WAIT with `exe_done` in its first cycle).
- JMP period: 3 cycles.
- `mem_addr` and `mem_rd` are registered outputs. `mem_rd` is high for exactly one cycle per fetch.
- `instr_valid` is registered and never drops without a handshake.
- `halted` rises the cycle after the HLT handshake.
- Reset mid-operation: all outputs clear asynchronously and any instruction in flight is discarded. Fetch restarts at RESET_PC on the first clock edge after `rst_n` rises.
- A simultaneous `exe_done` and SKZ with `acc_zero` in the same WAIT cycle produces a single skip: pc advances by 2 in total for that instruction.

## Configuration
- Macro: `FETCH_HALT_EN`.
- Defined: HLT behaves as described above and enters HALT with `halted`=1.
- Undefined: HLT is treated as a no-op.
  - It is still issued downstream and goes ISSUE -> WAIT -> FETCH with pc+1.
  - HALT state is not built and `halted` is tied to 0.

## Test plan
- Reset with RESET_PC=0, memory[0]=8'h45 (ADD @5), ready=1, `exe_done` pulsed in the first WAIT cycle -> `mem_rd` at cycle 0, `instr_valid` at cycle 2 with `opcode`=3'b010 and `address`=5'd5; next `mem_addr`=1 at cycle 4.
- memory[0]=8'hEA (JMP 10) -> after the handshake, the next `mem_addr`=10 with no `exe_done` required.
- memory[3]=8'h20 (SKZ), `acc_zero`=1 at `exe_done` -> next fetch address 5; repeat with `acc_zero`=0 -> next fetch address 4.
- `instr_ready` held low for 5 cycles in ISSUE -> `instr_valid` stays 1 and `opcode`/`address` stay stable; advance occurs only on the ready cycle.
- HLT at memory[2] with `FETCH_HALT_EN` -> `halted`=1 and no further `mem_rd`. Without the macro -> a fetch of address 3 follows.
- Drop `rst_n` during WAIT with pc=31 -> all outputs clear immediately; after release the fetch is at address 0. A separate run with pc=31 and ADD verifies the next fetch wraps to address 0.
